// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared constants for the pipeline control sequencer (opcodes, FSM states, control-word layout).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Control word layout, MSB first:
  // {alu_op[1:0], mux_a[1:0], mux_b[1:0], mux_c, reg_write[1:0], byte_en, mem_write, r0_select}
  localparam int CTRL_W      = 12;
  localparam int ALU_LSB     = 10;
  localparam int MUXA_LSB    = 8;
  localparam int MUXB_LSB    = 6;
  localparam int MUXC_BIT    = 5;
  localparam int RW_LSB      = 3;
  localparam int BYTE_EN_BIT = 2;
  localparam int MEM_WR_BIT  = 1;
  localparam int R0_SEL_BIT  = 0;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_LBU  = 4'b1010;
  localparam logic [3:0] OP_SB   = 4'b1011;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_A    = 4'b1111;

  // Comparator result encoding
  localparam logic [1:0] BR_EQ = 2'b01;
  localparam logic [1:0] BR_GT = 2'b10;
  localparam logic [1:0] BR_LT = 2'b11;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_STALL  = 3'd2,
    ST_TRAP   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Assemble a control word; r0_select is left 0 and set by the sequencer on taken branches.
  function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [1:0] alu, input logic [1:0] muxa,
                                                input logic [1:0] muxb, input logic muxc,
                                                input logic [1:0] rw, input logic be,
                                                input logic mw);
    logic [CTRL_W-1:0] c;
    c                 = '0;
    c[ALU_LSB+:2]     = alu;
    c[MUXA_LSB+:2]    = muxa;
    c[MUXB_LSB+:2]    = muxb;
    c[MUXC_BIT]       = muxc;
    c[RW_LSB+:2]      = rw;
    c[BYTE_EN_BIT]    = be;
    c[MEM_WR_BIT]     = mw;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Purpose: combinational opcode decode -> control word, known/halt flags and branch-taken flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer decides whether the decode is used.
// Ports: i_opcode, i_branch_result in; o_ctrl (control word), o_known (listed opcode),
//        o_halt, o_cond_br (conditional branch opcode), o_taken (branch taken or jmp) out.
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [1:0]        i_branch_result,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_known,
  output logic              o_halt,
  output logic              o_cond_br,
  output logic              o_taken
);

  always_comb begin
    o_ctrl    = '0;
    o_known   = 1'b0;
    o_halt    = 1'b0;
    o_cond_br = 1'b0;
    o_taken   = 1'b0;
    case (i_opcode)
      OPC_W'(OP_A): begin
        o_ctrl  = mk_ctrl(2'b01, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
        o_known = 1'b1;
      end
      OPC_W'(OP_ANDI): begin
        o_ctrl  = mk_ctrl(2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0);
        o_known = 1'b1;
      end
      OPC_W'(OP_ORI): begin
        o_ctrl  = mk_ctrl(2'b10, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0);
        o_known = 1'b1;
      end
      OPC_W'(OP_LBU): begin
        o_ctrl  = mk_ctrl(2'b11, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0);
        o_known = 1'b1;
      end
      OPC_W'(OP_LW): begin
        o_ctrl  = mk_ctrl(2'b11, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0);
        o_known = 1'b1;
      end
      OPC_W'(OP_SB): begin
        o_ctrl  = mk_ctrl(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);
        o_known = 1'b1;
      end
      OPC_W'(OP_SW): begin
        o_ctrl  = mk_ctrl(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
        o_known = 1'b1;
      end
      OPC_W'(OP_BGT): begin
        o_known   = 1'b1;
        o_cond_br = 1'b1;
        o_taken   = (i_branch_result == BR_GT);
      end
      OPC_W'(OP_BLT): begin
        o_known   = 1'b1;
        o_cond_br = 1'b1;
        o_taken   = (i_branch_result == BR_LT);
      end
      OPC_W'(OP_BEQ): begin
        o_known   = 1'b1;
        o_cond_br = 1'b1;
        o_taken   = (i_branch_result == BR_EQ);
      end
      OPC_W'(OP_JMP): begin
        o_known = 1'b1;
        o_taken = 1'b1;
      end
      OPC_W'(OP_HALT): begin
        o_known = 1'b1;
        o_halt  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Purpose: pipeline control sequencer: decodes the ID-stage opcode and steers flush/stall/trap/halt.
// Latency: 1 cycle, every output is registered from the inputs sampled at the clk edge.
// Backpressure: none accepted; the stall output is this block's hold request to the pipeline.
// Ports: clk, reset (sync, active-high), valid_in, opcode, branch_result, overflow_flag, load_use in;
//        ctrl_out, ctrl_valid, pc_op, b_jmp, if_flush, id_flush, ex_flush, stall, halt, trap, state out.
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int TRAP_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [OPC_W-1:0] opcode,
  input  logic [1:0]       branch_result,
  input  logic             overflow_flag,
  input  logic             load_use,
  output logic [11:0]      ctrl_out,
  output logic             ctrl_valid,
  output logic             pc_op,
  output logic             b_jmp,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             stall,
  output logic             halt,
  output logic             trap,
  output logic [2:0]       state
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  logic [CTRL_W-1:0] w_dec_ctrl;
  logic              w_known, w_halt_op, w_cond_br, w_taken, w_trap_ev, w_go_trap;

  state_e            r_state, w_nxt_state;
  logic [2:0]        r_cnt, w_nxt_cnt;
  logic [CTRL_W-1:0] r_ctrl, w_nxt_ctrl;
  logic r_ctrl_valid, r_pc_op, r_b_jmp, r_if_flush, r_id_flush, r_ex_flush, r_stall, r_halt, r_trap;
  logic w_nxt_ctrl_valid, w_nxt_pc_op, w_nxt_b_jmp, w_nxt_if_flush, w_nxt_id_flush;
  logic w_nxt_ex_flush, w_nxt_stall, w_nxt_halt, w_nxt_trap;

  pipe_ctrl_dec #(.OPC_W(OPC_W)) u_dec (
    .i_opcode        (opcode),
    .i_branch_result (branch_result),
    .o_ctrl          (w_dec_ctrl),
    .o_known         (w_known),
    .o_halt          (w_halt_op),
    .o_cond_br       (w_cond_br),
    .o_taken         (w_taken)
  );

  assign w_trap_ev = (TRAP_EN != 0) && overflow_flag;

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_ctrl       = '0;
    w_nxt_ctrl_valid = 1'b0;
    w_nxt_pc_op      = 1'b0;
    w_nxt_b_jmp      = 1'b0;
    w_nxt_if_flush   = 1'b0;
    w_nxt_id_flush   = 1'b0;
    w_nxt_ex_flush   = 1'b0;
    w_nxt_stall      = 1'b0;
    w_nxt_halt       = 1'b0;
    w_nxt_trap       = 1'b0;
    w_go_trap        = 1'b0;
    case (r_state)
      ST_RUN: begin
        // An empty decode slot is a bubble and never moves the FSM.
        if (valid_in) begin
          if (w_trap_ev) begin
            w_go_trap = 1'b1;
          end else if (w_halt_op) begin
            w_nxt_state    = ST_HALTED;
            w_nxt_halt     = 1'b1;
            w_nxt_if_flush = 1'b1;
          end else if (w_taken) begin
            w_nxt_state             = ST_FLUSH;
            w_nxt_cnt               = FLUSH_LOAD;
            w_nxt_ctrl              = w_dec_ctrl;
            w_nxt_ctrl[R0_SEL_BIT]  = w_cond_br;
            w_nxt_ctrl_valid        = 1'b1;
            w_nxt_pc_op             = 1'b1;
            w_nxt_b_jmp             = w_cond_br;
            w_nxt_if_flush          = 1'b1;
            w_nxt_id_flush          = 1'b1;
          end else if (load_use) begin
            w_nxt_state = ST_STALL;
            w_nxt_stall = 1'b1;
          end else begin
            w_nxt_ctrl       = w_dec_ctrl;
            w_nxt_ctrl_valid = w_known;
          end
        end
      end
      ST_FLUSH: begin
        // The taken-branch cycle already counted as the first flush cycle.
        if (w_trap_ev) begin
          w_go_trap = 1'b1;
        end else if (r_cnt == 3'd0) begin
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_cnt      = r_cnt - 3'd1;
          w_nxt_if_flush = 1'b1;
          w_nxt_id_flush = 1'b1;
        end
      end
      ST_STALL: begin
        if (load_use) begin
          w_nxt_stall = 1'b1;
        end else begin
          w_nxt_state = ST_RUN;
        end
      end
      ST_TRAP: w_nxt_state = ST_RUN;
      ST_HALTED: begin
        w_nxt_halt     = 1'b1;
        w_nxt_if_flush = 1'b1;
      end
      default: begin
        w_nxt_state = ST_RUN;
        w_nxt_cnt   = 3'd0;
      end
    endcase

    if (w_go_trap) begin
      w_nxt_state    = ST_TRAP;
      w_nxt_cnt      = 3'd0;
      w_nxt_trap     = 1'b1;
      w_nxt_pc_op    = 1'b1;
      w_nxt_if_flush = 1'b1;
      w_nxt_id_flush = 1'b1;
      w_nxt_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_cnt        <= 3'd0;
      r_ctrl       <= '0;
      r_ctrl_valid <= 1'b0;
      r_pc_op      <= 1'b0;
      r_b_jmp      <= 1'b0;
      r_if_flush   <= 1'b0;
      r_id_flush   <= 1'b0;
      r_ex_flush   <= 1'b0;
      r_stall      <= 1'b0;
      r_halt       <= 1'b0;
      r_trap       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_ctrl       <= w_nxt_ctrl;
      r_ctrl_valid <= w_nxt_ctrl_valid;
      r_pc_op      <= w_nxt_pc_op;
      r_b_jmp      <= w_nxt_b_jmp;
      r_if_flush   <= w_nxt_if_flush;
      r_id_flush   <= w_nxt_id_flush;
      r_ex_flush   <= w_nxt_ex_flush;
      r_stall      <= w_nxt_stall;
      r_halt       <= w_nxt_halt;
      r_trap       <= w_nxt_trap;
    end
  end

  assign ctrl_out   = r_ctrl;
  assign ctrl_valid = r_ctrl_valid;
  assign pc_op      = r_pc_op;
  assign b_jmp      = r_b_jmp;
  assign if_flush   = r_if_flush;
  assign id_flush   = r_id_flush;
  assign ex_flush   = r_ex_flush;
  assign stall      = r_stall;
  assign halt       = r_halt;
  assign trap       = r_trap;
  assign state      = r_state;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Purpose: self-checking bench for pipe_ctrl_seq (default params and FLUSH_CYC=1/TRAP_EN=0 instance).
// Latency: outputs compared one cycle after the inputs are applied.
// Backpressure: n/a.
module tb_pipe_ctrl_seq;

  typedef struct packed {
    logic [11:0] ctrl;
    logic cv, pc, bj, ifl, idl, exl, stl, hlt, trp;
    logic [2:0] st;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, valid_in, overflow_flag, load_use;
  logic [3:0] opcode;
  logic [1:0] branch_result;

  logic [11:0] d0_ctrl, d1_ctrl;
  logic [2:0]  d0_st, d1_st;
  logic d0_cv, d0_pc, d0_bj, d0_if, d0_id, d0_ex, d0_stl, d0_hlt, d0_trp;
  logic d1_cv, d1_pc, d1_bj, d1_if, d1_id, d1_ex, d1_stl, d1_hlt, d1_trp;

  obs_t obs0, obs1, exp0, exp1;
  int   m_mode [2];
  int   m_fdone[2];
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_seq dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .branch_result(branch_result),
    .overflow_flag(overflow_flag), .load_use(load_use), .ctrl_out(d0_ctrl), .ctrl_valid(d0_cv),
    .pc_op(d0_pc), .b_jmp(d0_bj), .if_flush(d0_if), .id_flush(d0_id), .ex_flush(d0_ex),
    .stall(d0_stl), .halt(d0_hlt), .trap(d0_trp), .state(d0_st)
  );

  pipe_ctrl_seq #(.OPC_W(4), .FLUSH_CYC(1), .TRAP_EN(0)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .branch_result(branch_result),
    .overflow_flag(overflow_flag), .load_use(load_use), .ctrl_out(d1_ctrl), .ctrl_valid(d1_cv),
    .pc_op(d1_pc), .b_jmp(d1_bj), .if_flush(d1_if), .id_flush(d1_id), .ex_flush(d1_ex),
    .stall(d1_stl), .halt(d1_hlt), .trap(d1_trp), .state(d1_st)
  );

  assign obs0 = {d0_ctrl, d0_cv, d0_pc, d0_bj, d0_if, d0_id, d0_ex, d0_stl, d0_hlt, d0_trp, d0_st};
  assign obs1 = {d1_ctrl, d1_cv, d1_pc, d1_bj, d1_if, d1_id, d1_ex, d1_stl, d1_hlt, d1_trp, d1_st};

  // ---------------- reference model (decode table + mode rules) ----------------
  function automatic logic [11:0] ref_word(input logic [3:0] op);
    case (op)
      4'b1111: return 12'b01_00_00_1_11_0_0_0;
      4'b0001: return 12'b00_00_11_0_00_0_0_0;
      4'b0010: return 12'b10_00_11_0_00_0_0_0;
      4'b1010: return 12'b11_11_00_0_11_1_0_0;
      4'b1100: return 12'b11_11_00_0_11_0_0_0;
      4'b1011: return 12'b11_11_00_0_00_1_1_0;
      4'b1101: return 12'b11_11_00_0_00_0_1_0;
      default: return 12'h000;
    endcase
  endfunction

  function automatic bit ref_listed(input logic [3:0] op);
    return op inside {4'b1111, 4'b0001, 4'b0010, 4'b1010, 4'b1100, 4'b1011, 4'b1101,
                      4'b0100, 4'b0101, 4'b0110, 4'b0111};
  endfunction

  function automatic bit ref_taken(input logic [3:0] op, input logic [1:0] br);
    return (op == 4'b0111) || (op == 4'b0100 && br == 2'b10) ||
           (op == 4'b0101 && br == 2'b11) || (op == 4'b0110 && br == 2'b01);
  endfunction

  // Modes: 0 RUN, 1 FLUSH, 2 STALL, 3 TRAP, 4 HALTED. m_fdone counts flush cycles already produced.
  task automatic model_step(input int k, input int fc, input bit te, output obs_t o);
    bit trap_now, cond;
    o        = '0;
    trap_now = 1'b0;
    if (reset) begin
      m_mode[k]  = 0;
      m_fdone[k] = 0;
    end else begin
      case (m_mode[k])
        0: if (valid_in) begin
          if (te && overflow_flag) trap_now = 1'b1;
          else if (opcode == 4'b0000) m_mode[k] = 4;
          else if (ref_taken(opcode, branch_result)) begin
            cond       = (opcode != 4'b0111);
            o.ctrl     = cond ? 12'h001 : 12'h000;
            o.cv       = 1'b1;
            o.pc       = 1'b1;
            o.bj       = cond;
            o.ifl      = 1'b1;
            o.idl      = 1'b1;
            m_mode[k]  = 1;
            m_fdone[k] = 1;
          end else if (load_use) m_mode[k] = 2;
          else begin
            o.ctrl = ref_word(opcode);
            o.cv   = ref_listed(opcode);
          end
        end
        1: if (te && overflow_flag) trap_now = 1'b1;
           else if (m_fdone[k] < fc) begin
             m_fdone[k] = m_fdone[k] + 1;
             o.ifl = 1'b1;
             o.idl = 1'b1;
           end else m_mode[k] = 0;
        2: if (!load_use) m_mode[k] = 0;
        3: m_mode[k] = 0;
        default: ;
      endcase
      if (trap_now) begin
        m_mode[k]  = 3;
        m_fdone[k] = 0;
        o = '0;
        {o.trp, o.pc, o.ifl, o.idl, o.exl} = 5'b11111;
      end
      if (m_mode[k] == 2) o.stl = 1'b1;
      if (m_mode[k] == 4) begin
        o.hlt = 1'b1;
        o.ifl = 1'b1;
      end
    end
    o.st = 3'(m_mode[k]);
  endtask

  always @(posedge clk) begin
    model_step(0, 2, 1'b1, exp0);
    model_step(1, 1, 1'b0, exp1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (obs0 !== exp0) begin
        errors++;
        $display("FAIL model_dut0 t=%0t actual %h required %h", $time, obs0, exp0);
      end
      checks++;
      if (obs1 !== exp1) begin
        errors++;
        $display("FAIL model_dut1 t=%0t actual %h required %h", $time, obs1, exp1);
      end
    end
  end

  // ---------------- stimulus and literal pins ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  task automatic cyc(input bit v, input logic [3:0] op, input logic [1:0] br, input bit ovf,
                     input bit lu, input bit rst);
    valid_in      = v;
    opcode        = op;
    branch_result = br;
    overflow_flag = ovf;
    load_use      = lu;
    reset         = rst;
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 4'h0, 2'b00, 0, 0, 1);
    chk_on = 1'b1;
    cyc(1, 4'h7, 2'b00, 1, 1, 1);
    lit("reset_all_zero", 32'(obs0), 32'h0);

    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("lw_ctrl", 32'(d0_ctrl), 32'hF18);
    lit("lw_valid", 32'(d0_cv), 32'h1);
    cyc(1, 4'b1111, 2'b00, 0, 0, 0);
    lit("a_ctrl", 32'(d0_ctrl), 32'h438);
    cyc(1, 4'b0001, 2'b00, 0, 0, 0);
    cyc(1, 4'b0010, 2'b00, 0, 0, 0);
    cyc(1, 4'b1010, 2'b00, 0, 0, 0);
    lit("lbu_ctrl", 32'(d0_ctrl), 32'hF1C);
    cyc(1, 4'b1011, 2'b00, 0, 0, 0);
    cyc(1, 4'b1101, 2'b00, 0, 0, 0);
    lit("sw_ctrl", 32'(d0_ctrl), 32'hF02);
    cyc(1, 4'b1000, 2'b00, 0, 0, 0);
    lit("nop_valid", 32'(d0_cv), 32'h0);
    cyc(0, 4'b1100, 2'b00, 0, 0, 0);
    lit("bubble_valid", 32'(d0_cv), 32'h0);

    // beq taken: two flush cycles then RUN
    cyc(1, 4'b0110, 2'b01, 0, 0, 0);
    lit("beq_steer", 32'({d0_pc, d0_bj, d0_if, d0_id}), 32'hF);
    lit("beq_ctrl", 32'(d0_ctrl), 32'h001);
    lit("beq_state1", 32'(d0_st), 32'd1);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("flush2_state", 32'(d0_st), 32'd1);
    lit("flush2_if", 32'(d0_if), 32'h1);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("flush_exit_state", 32'(d0_st), 32'd0);
    lit("flush_exit_if", 32'(d0_if), 32'h0);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("after_flush_valid", 32'(d0_cv), 32'h1);

    cyc(1, 4'b0110, 2'b10, 0, 0, 0);
    lit("beq_nt_valid_pc", 32'({d0_cv, d0_pc}), 32'h2);
    cyc(1, 4'b0111, 2'b00, 0, 0, 0);
    lit("jmp_pc_bj", 32'({d0_pc, d0_bj}), 32'h2);
    cyc(1, 4'b1000, 2'b00, 0, 0, 0);
    cyc(1, 4'b1000, 2'b00, 0, 0, 0);

    // overflow beats a taken blt
    cyc(1, 4'b0101, 2'b11, 1, 0, 0);
    lit("trap_bits", 32'({d0_trp, d0_ex, d0_bj, d0_pc}), 32'hD);
    lit("trap_state", 32'(d0_st), 32'd3);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("trap_one_cycle", 32'({d0_trp, d0_st}), 32'h0);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);

    // load_use for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'b1100, 2'b00, 0, 1, 0);
      lit("stall_held", 32'({d0_stl, d0_cv}), 32'h2);
    end
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("stall_exit", 32'({d0_stl, d0_st}), 32'h0);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);

    // overflow during FLUSH
    cyc(1, 4'b0111, 2'b00, 0, 0, 0);
    cyc(1, 4'b1100, 2'b00, 1, 0, 0);
    lit("flush_trap_state", 32'(d0_st), 32'd3);
    cyc(1, 4'b1000, 2'b00, 0, 0, 0);

    // halt sticks through opcodes and overflow, only reset leaves it
    cyc(1, 4'b0000, 2'b00, 0, 0, 0);
    lit("halt_state", 32'({d0_hlt, d0_if, d0_st}), 32'h1C);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'(4'b1100 + i), 2'b01, i[0], i[1], 0);
      lit("halt_sticky", 32'({d0_hlt, d0_cv}), 32'h2);
    end
    cyc(1, 4'b0111, 2'b00, 1, 0, 1);
    lit("halt_reset", 32'(obs0), 32'h0);
    cyc(1, 4'b1100, 2'b00, 0, 0, 0);
    lit("first_after_reset", 32'(d0_ctrl), 32'hF18);

    // reset during FLUSH and during STALL
    cyc(1, 4'b0110, 2'b01, 0, 0, 0);
    cyc(1, 4'b1100, 2'b00, 0, 0, 1);
    lit("reset_mid_flush", 32'({d0_if, d0_st}), 32'h0);
    cyc(1, 4'b1100, 2'b00, 0, 1, 0);
    cyc(1, 4'b1100, 2'b00, 0, 1, 1);
    lit("reset_mid_stall", 32'({d0_stl, d0_st}), 32'h0);
    cyc(1, 4'b0100, 2'b10, 0, 0, 0);
    cyc(1, 4'b1000, 2'b00, 0, 0, 0);
    cyc(0, 4'b0000, 2'b00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_seq.md
PIPE_CTRL_SEQ -- requirements
Module: pipe_ctrl_seq

Interface
REQ-001 SHALL have parameter OPC_W, default 4, opcode width.
REQ-002 SHALL have parameter FLUSH_CYC, default 2, cycles IF/ID flush is held after a taken branch/jump (legal 1..7).
REQ-003 SHALL have parameter TRAP_EN, default 1, enables the overflow trap.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_in  in  1  decode slot holds a valid instruction.
REQ-007 SHALL have port opcode  in  OPC_W  instruction opcode.
REQ-008 SHALL have port branch_result  in  2  comparator result: 01 equal, 10 greater, 11 less.
REQ-009 SHALL have port overflow_flag  in  1  EX-stage arithmetic overflow.
REQ-010 SHALL have port load_use  in  1  load-use hazard detected.
REQ-011 SHALL have port ctrl_out  out  12  registered control word {alu_op[1:0], mux_a[1:0], mux_b[1:0], mux_c, reg_write[1:0], byte_en, mem_write, r0_select}.
REQ-012 SHALL have port ctrl_valid  out  1  ctrl_out carries a real instruction, not a bubble.
REQ-013 SHALL have ports pc_op, b_jmp, if_flush, id_flush, ex_flush, stall, halt, trap  out  1 each  pipeline steering.
REQ-014 SHALL have port state  out  3  current FSM state, debug.

Function
REQ-015 SHALL decode: 1111 A (alu 01, muxb 00, muxc 1, rw 11); 0001 andi (alu 00, muxb 11); 0010 ori (alu 10, muxb 11); 1010 lbu/1100 lw (alu 11, muxa 11, rw 11, byte_en 1/0); 1011 sb/1101 sw (alu 11, muxa 11, mem_write 1, byte_en 1/0); 0100 bgt, 0101 blt, 0110 beq, 0111 jmp, 0000 halt; all unlisted fields 0.
REQ-016 SHALL treat branches/jmp/halt as non-writing: mem_write 0, reg_write 00.
REQ-017 SHALL treat unlisted opcodes as NOP: ctrl_out all zero, ctrl_valid 0.
REQ-018 SHALL register all outputs; latency one clk from sampled inputs.
REQ-019 SHALL take a branch when bgt&result 10, blt&11, beq&01; jmp always taken.
REQ-020 SHALL implement states RUN(0), FLUSH(1), STALL(2), TRAP(3), HALTED(4).
REQ-021 RUN, event priority: overflow&TRAP_EN -> TRAP; else halt opcode -> HALTED; else taken branch/jmp -> FLUSH; else load_use -> STALL; else RUN.
REQ-022 RUN taken branch: pc_op 1, b_jmp 1 (branch) or 0 (jmp), r0_select 1 (branch), if_flush and id_flush 1; flush counter loaded FLUSH_CYC-1.
REQ-023 FLUSH: if_flush/id_flush held 1, ctrl_valid 0, counter decrements; at 0 -> RUN; new opcodes ignored; overflow -> TRAP.
REQ-024 STALL: stall 1, ctrl_valid 0, ctrl_out zero; stays while load_use 1, else RUN.
REQ-025 TRAP: exactly one cycle of trap, pc_op, if_flush, id_flush, ex_flush all 1, ctrl_valid 0; then RUN.
REQ-026 HALTED: halt and if_flush 1, ctrl_valid 0; exited only by reset; overflow ignored.
REQ-027 valid_in 0 in RUN SHALL produce a bubble (ctrl_valid 0) without a state change.
REQ-028 TRAP_EN 0 SHALL make overflow_flag a no-op in every state.

Reset
REQ-029 reset high at a clk edge SHALL force state RUN, all outputs 0, flush counter 0, overriding every event incl. mid-FLUSH, mid-STALL and HALTED.
REQ-030 First instruction after reset deassertion SHALL be decoded normally.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold opcode constants, state encoding, ctrl_out field offsets and width.
REQ-032 Combinational decode SHALL be sub-module pipe_ctrl_dec (opcode -> control word, taken flag); FSM and registers stay in pipe_ctrl_seq.

Verification
REQ-033 lw (1100) in RUN -> next cycle ctrl_out alu 11, muxa 11, rw 11, byte_en 0, ctrl_valid 1.
REQ-034 beq with branch_result 01, FLUSH_CYC 2 -> pc_op/b_jmp/if_flush/id_flush 1, FLUSH held 2 cycles, RUN on 3rd; beq with 10 -> not taken, ctrl_valid 1.
REQ-035 overflow_flag 1 coincident with taken blt -> TRAP wins: one-cycle trap/ex_flush, no b_jmp, then RUN.
REQ-036 load_use high 3 cycles -> stall 1 for 3 cycles, ctrl_valid 0, RUN on 4th.
REQ-037 halt (0000) -> halt 1 indefinitely with opcodes and overflow applied; reset 1 -> all outputs 0 next edge.
REQ-038 reset asserted mid-FLUSH -> counter cleared, state RUN, if_flush 0 next edge.
